// File: rtl/array_serializer_if.sv
// Output word stream of array_serializer: valid/ready handshake
// carrying element data, its index and an end-of-transfer marker.
interface array_serializer_if #(
   parameter int WIDTH = 16,
   parameter int IW    = 2
);
   logic [WIDTH-1:0] out_data;
   logic [IW-1:0]    out_index;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   modport master (
      output out_data,
      output out_index,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_index,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/array_serializer.sv
// Captures a packed array on start and streams it one element per handshake.
// Optional trailing XOR checksum word when ARRAY_SER_CHECKSUM_EN is defined.
module array_serializer #(
   parameter  int WIDTH = 16,
   parameter  int LEN   = 4,
   localparam int IW    = (LEN > 1) ? $clog2(LEN) : 1
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   start,
   input  logic [WIDTH*LEN-1:0]   in_packed,
   output logic                   busy,
   output logic                   done,
   array_serializer_if.master     out_if
);

   localparam logic [IW-1:0] LAST = IW'(LEN - 1);

`ifdef ARRAY_SER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

   state_t           state;
   state_t           nxt;
   logic [WIDTH-1:0] elem [LEN];
   logic [IW-1:0]    idx;
   logic             capture;
   logic             adv;
   logic             fin;

`ifdef ARRAY_SER_CHECKSUM_EN
   logic [WIDTH-1:0] csum;

   // XOR of every captured element, sent as the trailing word
   always_comb begin
      csum = '0;
      for (int i = 0; i < LEN; i++) begin
         csum = csum ^ elem[i];
      end
   end
`endif

   // State register; reset drops any transfer in flight
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Next state and handshake outputs, all decoded from current state
   always_comb begin
      nxt               = state;
      capture           = 1'b0;
      adv               = 1'b0;
      fin               = 1'b0;
      busy              = (state != IDLE);
      out_if.out_valid  = 1'b0;
      out_if.out_data   = '0;
      out_if.out_index  = '0;
      out_if.out_last   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               nxt     = SEND;
               capture = 1'b1;
            end
         end
         SEND: begin
            out_if.out_valid = 1'b1;
            out_if.out_data  = elem[idx];
            out_if.out_index = idx;
`ifdef ARRAY_SER_CHECKSUM_EN
            out_if.out_last  = 1'b0;
`else
            out_if.out_last  = (idx == LAST);
`endif
            if (out_if.out_ready) begin
               if (idx == LAST) begin
`ifdef ARRAY_SER_CHECKSUM_EN
                  nxt = CSUM;
`else
                  nxt = IDLE;
                  fin = 1'b1;
`endif
               end else begin
                  adv = 1'b1;
               end
            end
         end
`ifdef ARRAY_SER_CHECKSUM_EN
         CSUM: begin
            out_if.out_valid = 1'b1;
            out_if.out_data  = csum;
            out_if.out_index = '0;
            out_if.out_last  = 1'b1;
            if (out_if.out_ready) begin
               nxt = IDLE;
               fin = 1'b1;
            end
         end
`endif
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   // Shadow copy of the array, element pointer and done pulse
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < LEN; i++) begin
            elem[i] <= '0;
         end
         idx  <= '0;
         done <= 1'b0;
      end else begin
         done <= fin;
         if (capture) begin
            for (int i = 0; i < LEN; i++) begin
               elem[i] <= in_packed[i*WIDTH +: WIDTH];
            end
            idx <= '0;
         end else if (adv) begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_array_serializer.sv
// Directed bench for array_serializer: LEN=4 streaming, stalls,
// busy-start immunity, mid-transfer reset and a LEN=1 instance.
module tb_array_serializer;

   localparam int W  = 16;
   localparam int L  = 4;
   localparam int IW = 2;
`ifdef ARRAY_SER_CHECKSUM_EN
   localparam int NW  = L + 1;
   localparam int NW1 = 2;
`else
   localparam int NW  = L;
   localparam int NW1 = 1;
`endif
   localparam logic [63:0] BASE = 64'h4444_3333_2222_1111;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [63:0]   pk = '0;
   logic          busy;
   logic          done;
   logic          start1 = 1'b0;
   logic [15:0]   pk1 = '0;
   logic          busy1;
   logic          done1;

   int errs   = 0;
   int checks = 0;

   logic [15:0] exp_w [5];
   logic [1:0]  exp_i [5];

   always #5 clk = ~clk;

   array_serializer_if #(.WIDTH(W), .IW(IW)) bus ();
   array_serializer_if #(.WIDTH(W), .IW(1))  bus1 ();

   array_serializer #(.WIDTH(W), .LEN(L)) u_dut (
      .aclk      (clk),
      .aresetn   (rst_n),
      .start     (start),
      .in_packed (pk),
      .busy      (busy),
      .done      (done),
      .out_if    (bus)
   );

   array_serializer #(.WIDTH(W), .LEN(1)) u_dut1 (
      .aclk      (clk),
      .aresetn   (rst_n),
      .start     (start1),
      .in_packed (pk1),
      .busy      (busy1),
      .done      (done1),
      .out_if    (bus1)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Runs one LEN=4 transfer of BASE and checks every word.
   // stall: ready pattern 1,0,0 repeating; inject: busy start + new data.
   // started: start was already sampled; chain: restart in done cycle.
   task automatic xfer(input bit stall, input bit inject,
                       input bit started, input bit chain);
      int          n    = 0;
      int          cyc  = 0;
      bit          held = 1'b0;
      bit          inj  = 1'b0;
      logic [15:0] hd   = '0;
      logic [1:0]  hi   = '0;
      logic        hl   = 1'b0;
      logic        rdy;
      if (!started) begin
         @(negedge clk);
         pk    = BASE;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      while (n < NW && cyc < 200) begin
         rdy = stall ? (cyc % 3 == 0) : 1'b1;
         bus.out_ready = rdy;
         if (held) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_data",  64'(bus.out_data),  64'(hd));
            check("hold_index", 64'(bus.out_index), 64'(hi));
            check("hold_last",  64'(bus.out_last),  64'(hl));
         end
         if (!stall) check("no_bubble", 64'(bus.out_valid), 64'd1);
         held = 1'b0;
         if (bus.out_valid && rdy) begin
            check("word_data",  64'(bus.out_data),  64'(exp_w[n]));
            check("word_index", 64'(bus.out_index), 64'(exp_i[n]));
            check("word_last",  64'(bus.out_last),  64'(n == NW-1));
            n++;
         end else if (bus.out_valid) begin
            held = 1'b1;
            hd   = bus.out_data;
            hi   = bus.out_index;
            hl   = bus.out_last;
         end
         if (inject && n == 2 && !inj) begin
            pk    = '1;
            start = 1'b1;
            inj   = 1'b1;
            check("busy_inject", 64'(busy), 64'd1);
         end else begin
            start = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      check("word_count", 64'(n), 64'(NW));
      check("done_pulse", 64'(done), 64'd1);
      check("done_idle",  64'(busy), 64'd0);
      check("done_valid", 64'(bus.out_valid), 64'd0);
      if (chain) begin
         pk    = BASE;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end else begin
         @(negedge clk);
         check("done_end", 64'(done), 64'd0);
      end
   endtask

   initial begin
      exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h4444};
      exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      bus.out_ready  = 1'b1;
      bus1.out_ready = 1'b1;

      // reset state
      #12;
      check("rst_busy",  64'(busy), 64'd0);
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_data",  64'(bus.out_data),  64'd0);
      check("rst_index", 64'(bus.out_index), 64'd0);
      check("rst_last",  64'(bus.out_last),  64'd0);
      check("rst_done",  64'(done), 64'd0);

      // first start on the first edge out of reset, streaming
      @(negedge clk);
      rst_n = 1'b1;
      pk    = BASE;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("first_busy", 64'(busy), 64'd1);
      xfer(1'b0, 1'b0, 1'b1, 1'b1);

      // back-to-back start in the done cycle, then stalled transfer
      xfer(1'b0, 1'b0, 1'b1, 1'b0);
      xfer(1'b1, 1'b0, 1'b0, 1'b0);

      // start and new data while busy must not disturb the transfer
      xfer(1'b0, 1'b1, 1'b0, 1'b0);

      // reset while index 2 is presented
      @(negedge clk);
      pk            = BASE;
      start         = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_index", 64'(bus.out_index), 64'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_data",  64'(bus.out_data),  64'd0);
      check("mid_rst_index", 64'(bus.out_index), 64'd0);
      check("mid_rst_busy",  64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_done", 64'(done), 64'd0);
      @(negedge clk);
      check("post_rst_done", 64'(done), 64'd0);
      xfer(1'b0, 1'b0, 1'b0, 1'b0);

      // single-element instance
      @(negedge clk);
      pk1    = 16'hABCD;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      pk1    = 16'h0000;
      for (int k = 0; k < NW1; k++) begin
         check("len1_valid", 64'(bus1.out_valid), 64'd1);
         check("len1_data",  64'(bus1.out_data),  64'hABCD);
         check("len1_index", 64'(bus1.out_index), 64'd0);
         check("len1_last",  64'(bus1.out_last),  64'(k == NW1-1));
         @(negedge clk);
      end
      check("len1_done", 64'(done1), 64'd1);
      check("len1_busy", 64'(busy1), 64'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
